// File: rtl/request_pool.sv
// Request store with a free-list allocator, per-entry age ranks, an oldest-match row CAM
// and a bank-busy probe. Retirement is one slot per cycle; flush keeps entry data.
module request_pool #(
    parameter int DEPTH  = 16,
    parameter int BG_W   = 2,
    parameter int BANK_W = 2,
    parameter int ROW_W  = 16,
    parameter int COL_W  = 10,
    localparam int ID_W   = $clog2(DEPTH),
    localparam int ADDR_W = BG_W + BANK_W + ROW_W + COL_W,
    localparam int TAG_W  = ADDR_W - COL_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              req_valid,
    input  logic [ADDR_W-1:0] req_addr,
    output logic              req_ready,
    output logic [ID_W-1:0]   alloc_id,
    input  logic              ret_valid,
    input  logic [ID_W-1:0]   ret_id,
    output logic              ret_err,
    input  logic [ID_W-1:0]   rd_addr,
    output logic [ADDR_W-1:0] rd_entry,
    output logic              rd_valid,
    output logic [ID_W-1:0]   rd_age,
    input  logic [TAG_W-1:0]  cam_tag,
    output logic              cam_hit,
    output logic [ID_W-1:0]   cam_id,
    output logic              bank_busy,
    output logic [ID_W:0]     count
);

    localparam logic [ID_W:0] DEPTH_C = (ID_W+1)'(DEPTH);

    logic [DEPTH-1:0]  valid;
    logic [ID_W-1:0]   age  [DEPTH];
    logic [ADDR_W-1:0] data [DEPTH];
    logic [ID_W-1:0]   fl   [DEPTH];
    logic [ID_W-1:0]   head;
    logic [ID_W-1:0]   tail;

    logic            enq;
    logic            ret_ok;
    logic            ret_bad;
    logic [ID_W-1:0] ret_age;
    logic [ID_W-1:0] best_age;

    assign req_ready = (count < DEPTH_C) && !flush;
    assign alloc_id  = fl[head];
    assign enq       = req_valid && req_ready;
    assign ret_ok    = ret_valid && valid[ret_id] && !flush;
    assign ret_bad   = ret_valid && !valid[ret_id] && !flush;
    assign ret_age   = age[ret_id];

    // Oldest match wins: ages of valid entries are unique, so the max is unambiguous.
    always_comb begin
        cam_hit   = 1'b0;
        cam_id    = '0;
        best_age  = '0;
        bank_busy = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (valid[i] && data[i][ADDR_W-1:COL_W] == cam_tag) begin
                if (!cam_hit || age[i] > best_age) begin
                    cam_hit  = 1'b1;
                    cam_id   = ID_W'(i);
                    best_age = age[i];
                end
            end
            if (valid[i] && data[i][ADDR_W-1:COL_W+ROW_W] == cam_tag[TAG_W-1:ROW_W])
                bank_busy = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                age[i]  <= '0;
                data[i] <= '0;
                fl[i]   <= ID_W'(i);
            end
            valid    <= '0;
            head     <= '0;
            tail     <= '0;
            count    <= '0;
            ret_err  <= 1'b0;
            rd_entry <= '0;
            rd_valid <= 1'b0;
            rd_age   <= '0;
        end else if (flush) begin
            for (int i = 0; i < DEPTH; i++) begin
                age[i] <= '0;
                fl[i]  <= ID_W'(i);
            end
            valid    <= '0;
            head     <= '0;
            tail     <= '0;
            count    <= '0;
            ret_err  <= 1'b0;
            rd_entry <= '0;
            rd_valid <= 1'b0;
            rd_age   <= '0;
        end else begin
            rd_entry <= data[rd_addr];
            rd_valid <= valid[rd_addr];
            rd_age   <= age[rd_addr];
            ret_err  <= ret_bad;

            for (int i = 0; i < DEPTH; i++) begin
                if (enq && ID_W'(i) == alloc_id) begin
                    valid[i] <= 1'b1;
                    age[i]   <= '0;
                    data[i]  <= req_addr;
                end else if (ret_ok && ID_W'(i) == ret_id) begin
                    valid[i] <= 1'b0;
                    age[i]   <= '0;
                end else if (valid[i]) begin
                    age[i] <= age[i] + ID_W'(enq) - ID_W'(ret_ok && (age[i] > ret_age));
                end
            end

            // The freed id lands at the tail, so it cannot be this cycle's alloc_id.
            if (enq)
                head <= head + ID_W'(1);
            if (ret_ok) begin
                fl[tail] <= ret_id;
                tail     <= tail + ID_W'(1);
            end

            if (enq && !ret_ok)
                count <= count + (ID_W+1)'(1);
            else if (ret_ok && !enq)
                count <= count - (ID_W+1)'(1);
        end
    end

endmodule

// File: tb/tb_request_pool.sv
// Self-checking bench for request_pool: directed table, hand sequences for the corner
// cases, and randomized traffic against an insertion-order reference model.
module tb_request_pool;

    localparam int DEPTH = 16;
    localparam int ID_W = 4;
    localparam int ADDR_W = 30;
    localparam int TAG_W = 20;
    localparam int COL_W = 10;
    localparam int ROW_W = 16;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              flush;
    logic              req_valid;
    logic [ADDR_W-1:0] req_addr;
    logic              req_ready;
    logic [ID_W-1:0]   alloc_id;
    logic              ret_valid;
    logic [ID_W-1:0]   ret_id;
    logic              ret_err;
    logic [ID_W-1:0]   rd_addr;
    logic [ADDR_W-1:0] rd_entry;
    logic              rd_valid;
    logic [ID_W-1:0]   rd_age;
    logic [TAG_W-1:0]  cam_tag;
    logic              cam_hit;
    logic [ID_W-1:0]   cam_id;
    logic              bank_busy;
    logic [ID_W:0]     count;

    request_pool dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .req_valid(req_valid), .req_addr(req_addr), .req_ready(req_ready), .alloc_id(alloc_id),
        .ret_valid(ret_valid), .ret_id(ret_id), .ret_err(ret_err),
        .rd_addr(rd_addr), .rd_entry(rd_entry), .rd_valid(rd_valid), .rd_age(rd_age),
        .cam_tag(cam_tag), .cam_hit(cam_hit), .cam_id(cam_id), .bank_busy(bank_busy),
        .count(count)
    );

    always #5 clk = ~clk;

    int passed = 0;
    int total = 0;

    // Reference model: ord holds valid slots oldest-first; age = distance from the newest.
    int ord[$];
    int fl[$];
    logic [ADDR_W-1:0] m_data [DEPTH];
    logic              exp_ret_err;
    logic [ADDR_W-1:0] exp_rd_entry;
    logic              exp_rd_valid;
    int                exp_rd_age;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp)
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        else
            passed++;
    endtask

    function automatic int find(input int s);
        for (int k = 0; k < ord.size(); k++)
            if (ord[k] == s) return k;
        return -1;
    endfunction

    function automatic int m_age(input int s);
        int k;
        k = find(s);
        return (k < 0) ? 0 : ord.size() - 1 - k;
    endfunction

    function automatic logic [ADDR_W-1:0] mk(input int bg, input int bk, input int row, input int col);
        return {2'(bg), 2'(bk), 16'(row), 10'(col)};
    endfunction

    task automatic model_reset(input bit keep_data);
        ord.delete();
        fl.delete();
        for (int s = 0; s < DEPTH; s++) begin
            fl.push_back(s);
            if (!keep_data) m_data[s] = '0;
        end
        exp_ret_err  = 1'b0;
        exp_rd_entry = '0;
        exp_rd_valid = 1'b0;
        exp_rd_age   = 0;
    endtask

    task automatic check_model();
        bit hit;
        int id;
        bit busy;
        hit = 0; id = 0; busy = 0;
        foreach (ord[k]) begin
            if (!hit && m_data[ord[k]][ADDR_W-1:COL_W] == cam_tag) begin
                hit = 1; id = ord[k];
            end
            if (m_data[ord[k]][ADDR_W-1:COL_W+ROW_W] == cam_tag[TAG_W-1:ROW_W]) busy = 1;
        end
        chk("req_ready", 32'(req_ready), 32'(!flush && ord.size() < DEPTH));
        chk("count", 32'(count), 32'(ord.size()));
        if (ord.size() < DEPTH) chk("alloc_id", 32'(alloc_id), 32'(fl[0]));
        chk("cam_hit", 32'(cam_hit), 32'(hit));
        chk("cam_id", 32'(cam_id), 32'(id));
        chk("bank_busy", 32'(bank_busy), 32'(busy));
        chk("ret_err", 32'(ret_err), 32'(exp_ret_err));
        chk("rd_entry", 32'(rd_entry), 32'(exp_rd_entry));
        chk("rd_valid", 32'(rd_valid), 32'(exp_rd_valid));
        chk("rd_age", 32'(rd_age), 32'(exp_rd_age));
    endtask

    task automatic model_tick();
        bit enq;
        bit rok;
        int a;
        if (flush) begin
            model_reset(1);
            return;
        end
        exp_rd_entry = m_data[rd_addr];
        exp_rd_valid = (find(int'(rd_addr)) >= 0);
        exp_rd_age   = m_age(int'(rd_addr));
        enq = req_valid && (ord.size() < DEPTH);
        rok = ret_valid && (find(int'(ret_id)) >= 0);
        exp_ret_err = ret_valid && !rok;
        if (rok) ord.delete(find(int'(ret_id)));
        if (enq) begin
            a = fl.pop_front();
            ord.push_back(a);
            m_data[a] = req_addr;
        end
        if (rok) fl.push_back(int'(ret_id));
    endtask

    task automatic cyc();
        @(negedge clk);
        check_model();
        model_tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        flush = 0; req_valid = 0; ret_valid = 0;
    endtask

    task automatic enq_one(input logic [ADDR_W-1:0] a);
        idle(); req_valid = 1; req_addr = a;
        cyc();
        idle();
    endtask

    task automatic do_flush();
        idle(); flush = 1;
        cyc();
        idle();
    endtask

    typedef struct {
        logic              rv;
        logic [ADDR_W-1:0] addr;
        logic [ID_W-1:0]   exp_alloc;
        logic [ID_W:0]     exp_count;
    } vec_t;

    vec_t tbl[3];

    initial begin
        tbl[0] = '{1'b1, 30'h0123_4567, 4'd0, 5'd1};
        tbl[1] = '{1'b1, 30'h0ABC_0001, 4'd1, 5'd2};
        tbl[2] = '{1'b1, 30'h1555_0402, 4'd2, 5'd3};

        rst_n = 0; idle(); req_addr = '0; ret_id = '0; rd_addr = '0; cam_tag = '0;
        model_reset(0);
        repeat (2) @(posedge clk);
        #1;
        chk("rst_count", 32'(count), 0);
        chk("rst_ready", 32'(req_ready), 1);
        chk("rst_alloc", 32'(alloc_id), 0);
        chk("rst_ret_err", 32'(ret_err), 0);
        chk("rst_rd_valid", 32'(rd_valid), 0);
        rst_n = 1;

        // Three enqueues into a fresh pool
        for (int v = 0; v < 3; v++) begin
            req_valid = tbl[v].rv; req_addr = tbl[v].addr;
            #1;
            chk("tbl_alloc", 32'(alloc_id), 32'(tbl[v].exp_alloc));
            cyc();
            chk("tbl_count", 32'(count), 32'(tbl[v].exp_count));
        end
        idle();
        for (int s = 0; s < 3; s++) begin
            rd_addr = ID_W'(s);
            cyc();
            #1;
            chk("age_after_3", 32'(rd_age), 32'(2 - s));
        end

        // Fill, retire 5 while full, then reuse 5
        do_flush();
        for (int s = 0; s < DEPTH; s++) enq_one(mk(1, 1, s, s));
        #1;
        chk("full_ready", 32'(req_ready), 0);
        chk("full_count", 32'(count), 16);
        req_valid = 1; req_addr = mk(2, 2, 99, 1); ret_valid = 1; ret_id = 4'd5;
        cyc();
        idle(); #1;
        chk("after_ret_ready", 32'(req_ready), 1);
        chk("after_ret_alloc", 32'(alloc_id), 5);
        chk("after_ret_count", 32'(count), 15);
        enq_one(mk(2, 2, 99, 2));
        chk("refill_count", 32'(count), 16);

        // CAM oldest match, then fall through to the younger one
        do_flush();
        enq_one(mk(0, 1, 7, 0));
        enq_one(mk(3, 2, 42, 1));
        enq_one(mk(0, 0, 8, 2));
        enq_one(mk(3, 2, 42, 3));
        cam_tag = mk(3, 2, 42, 0) >> COL_W; #1;
        chk("cam_hit_two", 32'(cam_hit), 1);
        chk("cam_id_oldest", 32'(cam_id), 1);
        ret_valid = 1; ret_id = 4'd1;
        cyc();
        idle(); #1;
        chk("cam_id_after_ret", 32'(cam_id), 3);
        chk("bank_busy_hit", 32'(bank_busy), 1);

        // Simultaneous enqueue and retire at count 3
        do_flush();
        for (int s = 0; s < 3; s++) enq_one(mk(1, 0, s, 5));
        req_valid = 1; req_addr = mk(1, 3, 77, 9); ret_valid = 1; ret_id = 4'd0;
        cyc();
        idle(); #1;
        chk("simul_count", 32'(count), 3);
        rd_addr = 4'd3;
        cyc(); #1;
        chk("simul_new_age", 32'(rd_age), 0);
        chk("simul_new_valid", 32'(rd_valid), 1);
        rd_addr = 4'd1;
        cyc(); #1;
        chk("simul_old_age", 32'(rd_age), 2);

        // Retire an invalid slot
        ret_valid = 1; ret_id = 4'd7;
        cyc();
        idle(); #1;
        chk("ret_err_pulse", 32'(ret_err), 1);
        chk("ret_err_count", 32'(count), 3);
        cyc(); #1;
        chk("ret_err_clear", 32'(ret_err), 0);

        // Flush with a concurrent request
        cam_tag = mk(1, 3, 77, 0) >> COL_W;
        flush = 1; req_valid = 1; req_addr = mk(0, 0, 1, 1);
        cyc();
        idle(); #1;
        chk("flush_count", 32'(count), 0);
        chk("flush_alloc", 32'(alloc_id), 0);
        chk("flush_bank_busy", 32'(bank_busy), 0);

        // Randomized traffic
        for (int n = 0; n < 600; n++) begin
            idle();
            flush     = ($urandom_range(0, 49) == 0);
            req_valid = ($urandom_range(0, 1) == 1);
            req_addr  = mk($urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 2), $urandom_range(0, 1023));
            ret_valid = ($urandom_range(0, 9) < 4);
            if (ord.size() > 0 && $urandom_range(0, 3) != 0)
                ret_id = ID_W'(ord[$urandom_range(0, ord.size() - 1)]);
            else
                ret_id = ID_W'($urandom_range(0, DEPTH - 1));
            rd_addr = ID_W'($urandom_range(0, DEPTH - 1));
            cam_tag = mk($urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 2), 0) >> COL_W;
            cyc();
        end

        // Reset asserted between edges takes effect immediately
        idle(); req_valid = 1;
        cyc();
        rst_n = 0; #1;
        chk("midrst_count", 32'(count), 0);
        chk("midrst_alloc", 32'(alloc_id), 0);
        chk("midrst_rd_entry", 32'(rd_entry), 0);
        model_reset(0);
        idle();
        @(posedge clk); #2;
        rst_n = 1;
        cyc();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
